// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with busy/done handshake and flush support.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nx;

    logic [1:0]        op_q;
    logic [TAG_W-1:0]  rd_q;
    logic              neg_q;
    logic              sa_q;
    logic              special_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc;

    logic              accept, last;
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   sp_res;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign last     = (cnt == CW'(XLEN-1));
    assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign sa       = a_signed & op_a[XLEN-1];
    assign sb       = b_signed & op_b[XLEN-1];
    assign a_mag    = sa ? -op_a : op_a;
    assign b_mag    = sb ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = ~funct3[0] && (op_a == MIN_NEG) && (op_b == '1);

    always_comb begin
        sp_res = '0;
        if (div_zero)     sp_res = funct3[1] ? op_a : '1;
        else if (div_ovf) sp_res = funct3[1] ? '0 : op_a;
    end

    // Shared accumulator: MUL keeps {product_hi, multiplier}; DIV keeps {remainder, dividend/quotient}.
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;
    logic [XLEN-1:0]   mul_res, quo, rmd, div_res;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd_q : '0)};
    assign mul_nx   = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, opnd_q};
    assign q_bit    = ~div_diff[XLEN];
    assign div_nx   = {(q_bit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], q_bit};

    assign prod    = neg_q ? -mul_nx : mul_nx;
    assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign quo     = neg_q ? -div_nx[XLEN-1:0] : div_nx[XLEN-1:0];
    assign rmd     = sa_q ? -div_nx[2*XLEN-1:XLEN] : div_nx[2*XLEN-1:XLEN];
    assign div_res = op_q[1] ? rmd : quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_IDLE:  if (accept) state_nx = funct3[2] ? S_DIV : S_MUL;
            S_MUL:   if (flush) state_nx = S_IDLE;
                     else if (last) state_nx = S_DONE;
            S_DIV:   if (flush) state_nx = S_IDLE;
                     else if (special_q || last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            sa_q      <= 1'b0;
            special_q <= 1'b0;
            cnt       <= '0;
            opnd_q    <= '0;
            acc       <= '0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            if (accept) begin
                op_q      <= funct3[1:0];
                rd_q      <= rd_in;
                neg_q     <= sa ^ sb;
                sa_q      <= sa;
                special_q <= funct3[2] && (div_zero || div_ovf);
                cnt       <= '0;
                if (!funct3[2]) begin
                    opnd_q <= a_mag;
                    acc    <= {{XLEN{1'b0}}, b_mag};
                end else begin
                    opnd_q <= b_mag;
                    acc    <= {{XLEN{1'b0}}, (div_zero || div_ovf) ? sp_res : a_mag};
                end
            end else if (state == S_MUL && !flush) begin
                acc <= mul_nx;
                cnt <= cnt + CW'(1);
                if (last) begin
                    result <= mul_res;
                    rd_out <= rd_q;
                end
            end else if (state == S_DIV && !flush) begin
                if (special_q) begin
                    result <= acc[XLEN-1:0];
                    rd_out <= rd_q;
                end else begin
                    acc <= div_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result <= div_res;
                        rd_out <= rd_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32 with hand-computed results.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the period right after the edge that samples start.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_cycle);
        int cyc;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_cycle);
        check({tag, "_busy_run"}, {31'b0, busy_ok & busy}, 32'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
        @(posedge clk); #1;
        check({tag, "_back_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd10, 32'hFFFFFFEB, 33);
        run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33);
        run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);
        run_op("mulh_neg", 3'b001, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFFF, 33);
        run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run_op("divu",     3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33);
        run_op("remu",     3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33);
        run_op("div_nb",   3'b100, 32'd100,      32'hFFFFFFF9, 5'd9,  32'hFFFFFFF2, 33);
        run_op("rem_nb",   3'b110, 32'd100,      32'hFFFFFFF9, 5'd11, 32'd2,        33);
        run_op("divu_z",   3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 2);
        run_op("rem_z",    3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        2);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 2);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        2);
        run_op("divu_big", 3'b101, 32'hFFFFFFFF, 32'd1,        5'd16, 32'hFFFFFFFF, 33);

        // flush of an in-flight divide: no done, result/rd_out keep previous values
        begin
            int seen_done;
            @(negedge clk);
            start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) begin @(posedge clk); #1; end
            check("flush_pre_busy", {31'b0, busy}, 32'd1);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush_busy", {31'b0, busy}, 32'd0);
            seen_done = 0;
            repeat (40) begin
                if (done) seen_done++;
                @(posedge clk); #1;
            end
            check("flush_no_done", seen_done, 0);
            check("flush_result", result, 32'hFFFFFFFF);
            check("flush_rd", {27'b0, rd_out}, 32'd16);
        end

        // start together with flush in IDLE is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd21;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("start_flush_busy2", {31'b0, busy}, 32'd0);

        // start pulses during busy must not disturb the in-flight multiply
        begin
            int cyc;
            @(negedge clk);
            start = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd22;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 1;
            while (!done && cyc < 40) begin
                if (cyc >= 5 && cyc <= 9) begin
                    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd9; rd_in = 5'd23;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
            start = 1'b0;
            check("busy_start_latency", cyc, 33);
            check("busy_start_result", result, 32'd42);
            check("busy_start_rd", {27'b0, rd_out}, 32'd22);
            @(posedge clk); #1;
        end

        // asynchronous reset in the middle of a multiply
        begin
            @(negedge clk);
            start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd24;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (14) begin @(posedge clk); #1; end
            check("rst_mid_pre_busy", {31'b0, busy}, 32'd1);
            #2 reset = 1'b1;
            #1;
            check("rst_mid_busy", {31'b0, busy}, 32'd0);
            check("rst_mid_done", {31'b0, done}, 32'd0);
            check("rst_mid_result", result, 32'd0);
            check("rst_mid_rd", {27'b0, rd_out}, 32'd0);
            @(negedge clk);
            reset = 1'b0;
        end

        run_op("post_rst", 3'b000, 32'd9, 32'd9, 5'd25, 32'd81, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the EX stage of the pipelined core. It extends the base integer ALU with MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a parametrised datapath width. It accepts one operation per start pulse, raises busy so the hazard logic can stall IF/ID/EX, and returns the result with a one-cycle done pulse. It supports pipeline flush on branch/jump redirect.

Parameters:
XLEN, 32, operand/result width in bits (>=8, power of 2)
TAG_W, 5, width of destination-register tag carried with the op

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; sampled only in IDLE
funct3  in  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
rd_in  in  TAG_W  destination tag
flush  in  1  abort in-flight op (branch/jump taken in MEM)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, result/rd_out valid
result  out  XLEN  final result, held until next accepted op completes
rd_out  out  TAG_W  tag of completed op, held with result

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, rd_out=0, all internal regs 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE: start=1 and flush=0 -> latch funct3, rd_in, sign flags, |op_a|, |op_b| (magnitudes only for signed operands per op); iteration counter=0; go to MUL (funct3[2]=0) or DIV (funct3[2]=1). start with flush=1 is ignored.
- DIV special cases detected at accept, go straight to DONE (done 2 cycles after the start edge):
  - op_b==0 -> DIV/DIVU result all-ones; REM/REMU result op_a.
  - DIV/REM with op_a=most-negative and op_b=-1 -> DIV result op_a; REM result 0.
- MUL: radix-2 shift-add, one bit per cycle, 2*XLEN-bit accumulator; XLEN cycles, then DONE.
- DIV: restoring shift-subtract, one quotient bit per cycle; XLEN cycles, then DONE.
- Sign fixup, applied combinationally on the final iteration and registered into result on entry to DONE:
  - product negated when signs differ (MULH: both signed; MULHSU: op_a signed only).
  - quotient sign = sa^sb.
  - remainder sign = sa.
- Result select: MUL returns low XLEN bits; MULH* returns high XLEN bits.
- Latency: start edge at cycle 0; done=1 in cycle XLEN+1 (33 for XLEN=32); state returns to IDLE at cycle XLEN+2.
- Throughput: one op per XLEN+2 cycles; start is accepted only in IDLE, never in DONE.
- busy=1 in MUL, DIV, DONE; busy=0 in IDLE, including the cycle start is sampled. Hazard logic ORs start into its stall.
- flush in MUL/DIV -> IDLE next edge. No done pulse. result and rd_out keep their previous values.
- flush in DONE: done still pulses that cycle; the consumer discards it.
- start while busy: ignored, with no effect on the in-flight op.
- Reset mid-operation: immediate return to reset values; no done pulse.
- All arithmetic is modulo 2^XLEN on result; there are no exceptions or flags.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (XLEN=32) -> done exactly 33 cycles after start, result=0xFFFFFFEB, rd_out=rd_in=5'd10, busy high cycles 1..33.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; all with done at cycle 33.
4. DIVU 5/0 -> 0xFFFFFFFF, done at cycle 2; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
5. DIV started, flush at cycle 10 -> busy=0 at cycle 11, done never pulses, result unchanged; start asserted with flush in IDLE -> ignored, busy stays 0.
6. Reset asserted mid-MUL at cycle 15 -> busy=0, done=0, result=0 immediately (asynchronously); start during busy never alters the in-flight result.
